// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter sharing logic.
package uart_pkg;

    localparam int unsigned PAYLOAD_BITS_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte handshakes plus the transmitter en/data/busy link.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF
);

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]              req_last;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            tx_en;
    logic [PAYLOAD_BITS-1:0]         tx_data;
    logic                            tx_busy;

    // Requesters and transmitter side
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_en, tx_data
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_en, tx_data
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid scanning upward from ptr, wrapping at N.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int unsigned c;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            // Explicit wrap keeps non-power-of-two N correct
            c = 32'(ptr) + i;
            if (c >= N) c = c - N;
            if (!any && valid[IDX_W'(c)]) begin
                any = 1'b1;
                idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; a grant is held until a byte marked last
// has been sent, or until the locked owner idles for LOCK_TIMEOUT cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
    parameter int unsigned LOCK_TIMEOUT = 1023,
    localparam int unsigned IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_arbiter_if.slave     bus,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 active
);

    localparam int unsigned CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    state_t                                state_q, state_n;
    logic [IDX_W-1:0]                      rr_ptr_q, rr_ptr_n;
    logic [IDX_W-1:0]                      grant_q, grant_n;
    logic [IDX_W-1:0]                      pick_idx;
    logic                                  pick_any;
    logic                                  last_q, last_n;
    logic [PAYLOAD_BITS-1:0]               hold_q, hold_n;
    logic [CNT_W-1:0]                      cnt_q, cnt_n;
    logic                                  tx_en_q;
    logic                                  active_q;
    logic [NUM_REQ-1:0]                    ready_c;
    logic [NUM_REQ-1:0][PAYLOAD_BITS-1:0]  req_data_arr;

    assign req_data_arr = bus.req_data;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next-state, accept pulse and capture
    always_comb begin
        state_n  = state_q;
        rr_ptr_n = rr_ptr_q;
        grant_n  = grant_q;
        last_n   = last_q;
        hold_n   = hold_q;
        cnt_n    = cnt_q;
        ready_c  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.tx_busy && pick_any) begin
                    ready_c[pick_idx] = 1'b1;
                    hold_n            = req_data_arr[pick_idx];
                    last_n            = bus.req_last[pick_idx];
                    grant_n           = pick_idx;
                    state_n           = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_n = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        rr_ptr_n = wrap_inc(grant_q);
                        state_n  = ST_IDLE;
                    end else begin
                        cnt_n   = '0;
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.req_valid[grant_q]) begin
                    ready_c[grant_q] = 1'b1;
                    hold_n           = req_data_arr[grant_q];
                    last_n           = bus.req_last[grant_q];
                    state_n          = ST_LAUNCH;
                end else if (LOCK_TIMEOUT != 0 && cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    rr_ptr_n = wrap_inc(grant_q);
                    state_n  = ST_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            last_q   <= 1'b0;
            hold_q   <= '0;
            cnt_q    <= '0;
            tx_en_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            rr_ptr_q <= rr_ptr_n;
            grant_q  <= grant_n;
            last_q   <= last_n;
            hold_q   <= hold_n;
            cnt_q    <= cnt_n;
            tx_en_q  <= (state_n == ST_LAUNCH);
            active_q <= (state_n != ST_IDLE);
        end
    end

    // Accept pulse is combinational; masked while reset is held
    assign bus.req_ready = rst ? '0 : ready_c;
    assign bus.tx_en     = tx_en_q;
    assign bus.tx_data   = hold_q;
    assign grant_id      = grant_q;
    assign active        = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small busy-period transmitter model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned PB       = 8;
    localparam int unsigned LT       = 16;
    localparam int          BUSY_LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       active;

    logic [NUM_REQ-1:0] rv, rl;
    logic [PB-1:0]      rd [NUM_REQ];
    logic               busy_m, busy_force;
    int                 bcnt;

    int n_cmp = 0;
    int n_bad = 0;
    int onehot_err = 0;
    int bad_state_ready = 0;
    int en_busy_err = 0;
    int log_id [$];
    int log_data [$];

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .PAYLOAD_BITS(PB)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .PAYLOAD_BITS (PB),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .active   (active)
    );

    always #5 clk = ~clk;

    assign bus.req_valid = rv;
    assign bus.req_last  = rl;
    assign bus.req_data  = {rd[2], rd[1], rd[0]};
    assign bus.tx_busy   = busy_m | busy_force;

    // Transmitter model: busy rises the cycle after en and lasts BUSY_LEN cycles
    always @(posedge clk) begin
        if (rst) begin
            busy_m <= 1'b0;
            bcnt   <= 0;
        end else if (bus.tx_en && !busy_m) begin
            busy_m <= 1'b1;
            bcnt   <= BUSY_LEN;
        end else if (busy_m) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) busy_m <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.tx_en) begin
            log_id.push_back(int'(grant_id));
            log_data.push_back(int'(bus.tx_data));
            if (bus.tx_busy) en_busy_err <= en_busy_err + 1;
        end
    end

    always @(negedge clk) begin
        if ($countones(bus.req_ready) > 1) onehot_err <= onehot_err + 1;
        if (dut.state_q inside {ST_LAUNCH, ST_WAIT_BUSY, ST_WAIT_DONE} && bus.req_ready != '0)
            bad_state_ready <= bad_state_ready + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
        rv[r] = v;
        rd[r] = d;
        rl[r] = l;
    endtask

    task automatic wait_ready(input int r, input string tag);
        bit ok = 1'b0;
        #1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.req_ready[r]) ok = 1'b1;
            else begin step(); #1; end
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_state(input state_t s, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (dut.state_q == s) ok = 1'b1;
            else step();
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input logic val, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.tx_busy == val) ok = 1'b1;
            else step();
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_quiet(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!active && !bus.tx_busy) ok = 1'b1;
            else step();
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_log(input string tag, input int idx, input int exp_id, input int exp_data);
        check({tag, "_id"},   (idx < log_id.size())   ? 32'(log_id[idx])   : 32'hdead, 32'(exp_id));
        check({tag, "_data"}, (idx < log_data.size()) ? 32'(log_data[idx]) : 32'hdead, 32'(exp_data));
    endtask

    initial begin
        int n;
        int hold_rdy;
        int guard_err;
        rv = '0;
        rl = '0;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = '0;
        busy_force = 1'b0;
        rst = 1'b1;
        repeat (3) step();

        check("rst_tx_en",  32'(bus.tx_en),     32'd0);
        check("rst_ready",  32'(bus.req_ready), 32'd0);
        check("rst_active", 32'(active),        32'd0);
        check("rst_grant",  32'(grant_id),      32'd0);
        check("rst_rr_ptr", 32'(dut.rr_ptr_q),  32'd0);
        rst = 1'b0;
        step();

        // Single byte from req0
        set_req(0, 1'b1, 8'h55, 1'b1);
        wait_ready(0, "t1_ready");
        check("t1_ready_vec", 32'(bus.req_ready), 32'b001);
        step();
        rv[0] = 1'b0;
        check("t1_tx_en",   32'(bus.tx_en),   32'd1);
        check("t1_tx_data", 32'(bus.tx_data), 32'h55);
        check("t1_active",  32'(active),      32'd1);
        wait_busy(1'b1, "t1_busy_hi");
        wait_busy(1'b0, "t1_busy_lo");
        step();
        check("t1_active_after", 32'(active),       32'd0);
        check("t1_rr_ptr",       32'(dut.rr_ptr_q), 32'd1);

        // Round robin from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        log_id.delete();
        log_data.delete();
        set_req(0, 1'b1, 8'hA0, 1'b1);
        set_req(1, 1'b1, 8'hA1, 1'b1);
        set_req(2, 1'b1, 8'hA2, 1'b1);
        for (int i = 0; i < 400 && log_id.size() < 4; i++) step();
        rv = '0;
        wait_quiet("t2_quiet");
        check("t2_count", 32'(log_id.size()), 32'd4);
        check_log("t2_0", 0, 0, 8'hA0);
        check_log("t2_1", 1, 1, 8'hA1);
        check_log("t2_2", 2, 2, 8'hA2);
        check_log("t2_3", 3, 0, 8'hA0);

        // Locked two-byte message from req1 while req0 waits
        log_id.delete();
        log_data.delete();
        set_req(0, 1'b1, 8'h11, 1'b1);
        set_req(1, 1'b1, 8'h48, 1'b0);
        wait_ready(1, "t3_b0");
        step();
        set_req(1, 1'b1, 8'h69, 1'b1);
        wait_ready(1, "t3_b1");
        check("t3_hold_state", 32'(dut.state_q), 32'(ST_HOLD));
        check("t3_grant",      32'(grant_id),    32'd1);
        step();
        rv[1] = 1'b0;
        wait_ready(0, "t3_r0");
        step();
        rv[0] = 1'b0;
        wait_quiet("t3_quiet");
        check_log("t3_0", 0, 1, 8'h48);
        check_log("t3_1", 1, 1, 8'h69);
        check_log("t3_2", 2, 0, 8'h11);

        // Lock timeout: req2 abandons its message, req0 waits
        set_req(2, 1'b1, 8'h77, 1'b0);
        set_req(0, 1'b1, 8'h22, 1'b1);
        wait_ready(2, "t4_r2");
        check("t4_ready_vec", 32'(bus.req_ready), 32'b100);
        step();
        rv[2] = 1'b0;
        wait_state(ST_HOLD, "t4_hold");
        n = 0;
        hold_rdy = 0;
        while (dut.state_q == ST_HOLD && n < 100) begin
            if (bus.req_ready != '0) hold_rdy++;
            step();
            n++;
        end
        check("t4_hold_cycles", 32'(n),        32'd16);
        check("t4_hold_ready",  32'(hold_rdy), 32'd0);
        #1;
        check("t4_idle_ready",  32'(bus.req_ready), 32'b001);
        check("t4_rr_ptr",      32'(dut.rr_ptr_q),  32'd0);
        step();
        rv[0] = 1'b0;
        wait_quiet("t4_quiet");

        // Reset while the transmitter is busy
        set_req(1, 1'b1, 8'h33, 1'b1);
        wait_ready(1, "t5_r1");
        step();
        rv[1] = 1'b0;
        wait_state(ST_WAIT_DONE, "t5_wait_done");
        rst = 1'b1;
        step();
        check("t5_tx_en",  32'(bus.tx_en),     32'd0);
        check("t5_ready",  32'(bus.req_ready), 32'd0);
        check("t5_active", 32'(active),        32'd0);
        check("t5_rr_ptr", 32'(dut.rr_ptr_q),  32'd0);
        rst = 1'b0;
        step();
        set_req(1, 1'b1, 8'h5A, 1'b1);
        wait_ready(1, "t5_again");
        check("t5_ready_vec", 32'(bus.req_ready), 32'b010);
        step();
        rv[1] = 1'b0;
        check("t5_tx_en_after", 32'(bus.tx_en),   32'd1);
        check("t5_tx_data",     32'(bus.tx_data), 32'h5A);
        check("t5_grant",       32'(grant_id),    32'd1);
        wait_quiet("t5_quiet");

        // Busy guard in IDLE
        busy_force = 1'b1;
        set_req(0, 1'b1, 8'hC3, 1'b1);
        guard_err = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.req_ready != '0 || bus.tx_en) guard_err++;
            step();
        end
        check("t6_guard", 32'(guard_err), 32'd0);
        busy_force = 1'b0;
        #1;
        check("t6_ready_vec", 32'(bus.req_ready), 32'b001);
        step();
        rv[0] = 1'b0;
        check("t6_tx_en",   32'(bus.tx_en),   32'd1);
        check("t6_tx_data", 32'(bus.tx_data), 32'hC3);
        wait_quiet("t6_quiet");

        check("onehot_ready",   32'(onehot_err),      32'd0);
        check("ready_in_xfer",  32'(bad_state_ready), 32'd0);
        check("en_during_busy", 32'(en_busy_err),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single UART transmitter between NUM_REQ requesters, such as the CPU debug port, a trace unit and a boot loader.
- Per-requester valid/ready byte interface with round-robin arbitration.
- A requester that does not mark a byte as `last` holds the transmitter, so multi-byte messages are never interleaved.
- Drives the transmitter's en/data inputs and watches its busy output.
- Sits between the requesters and the UART transmitter instance in the peripheral top.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- PAYLOAD_BITS, 8, bits per byte; must match the transmitter.
- LOCK_TIMEOUT, 1023, idle cycles a locked requester may hold the grant before it is forcibly released; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  byte offered by requester i.
- req_data  in  NUM_REQ*PAYLOAD_BITS  byte of requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- req_last  in  NUM_REQ  offered byte ends requester i's message.
- req_ready  out  NUM_REQ  one-hot single-cycle accept pulse.
- tx_en  out  1  to transmitter `uart_tx_en`.
- tx_data  out  PAYLOAD_BITS  to transmitter `uart_tx_data`.
- tx_busy  in  1  from transmitter `uart_tx_busy`.
- grant_id  out  max(1,$clog2(NUM_REQ))  current owner; valid while active=1.
- active  out  1  a grant is held (any state other than IDLE).

Behaviour:
- One clock domain; all state updates on posedge clk.
- Reset (rst=1, synchronous, may occur at any time, including mid-byte):
  - state=IDLE, rr_ptr=0, grant_id=0, lock=0, hold register=0, timeout counter=0.
  - tx_en=0 and req_ready=0 from the reset cycle onward.
  - The transmitter is reset by the same top-level reset; the arbiter never waits on a stale busy after reset.
- State IDLE:
  - If tx_busy=0 and any req_valid: pick the first valid requester scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational from state, valid and pointer); capture req_data[g] into the hold register and req_last[g] into lock_n; grant_id<=g; go to LAUNCH.
  - If tx_busy=1, wait.
- State LAUNCH:
  - tx_en=1 for exactly this one cycle; tx_data=hold register (tx_data is held stable from LAUNCH through WAIT_DONE).
  - Go to WAIT_BUSY.
- State WAIT_BUSY:
  - tx_en=0. When tx_busy=1, go to WAIT_DONE.
  - The transmitter raises busy the cycle after en, so this state normally lasts 1 cycle.
- State WAIT_DONE: when tx_busy=0:
  - If the last byte was marked last: release, rr_ptr<=(grant_id+1) mod NUM_REQ, go to IDLE.
  - Otherwise go to HOLD and clear the timeout counter.
- State HOLD:
  - Only requester grant_id is eligible; all other req_ready stay 0.
  - If req_valid[grant_id]: req_ready pulse, capture data/last, go to LAUNCH.
  - Otherwise increment the counter. When LOCK_TIMEOUT≠0 and counter==LOCK_TIMEOUT-1: release as above and go to IDLE.
- Throughput: acceptance to tx_en is 1 cycle. With the transmitter's 1-cycle idle gap, back-to-back bytes of one locked message are separated by 1 bit time plus 3 clk.
- Simultaneous valids are resolved solely by rr_ptr.
- A valid held across IDLE while tx_busy=1 waits without penalty.
- req_ready never asserts in LAUNCH, WAIT_BUSY or WAIT_DONE.
- At most one req_ready bit is high in any cycle.
- Arithmetic: rr_ptr wraps explicitly (compare to NUM_REQ-1), not by natural overflow, so non-power-of-two NUM_REQ works.
- Timeout counter width is $clog2(LOCK_TIMEOUT+1); it saturates, never wraps.

Decomposition:
- Shared package uart_pkg: state encoding constants (ST_IDLE=0, ST_LAUNCH=1, ST_WAIT_BUSY=2, ST_WAIT_DONE=3, ST_HOLD=4) and the PAYLOAD_BITS default.
- One natural sub-module: rr_pick. It is combinational; inputs are the valid vector and the pointer, outputs are the index and an any-valid flag. It is reusable by other shared-peripheral arbiters.
- The transmitter itself is instantiated beside this block, not inside it.

Test Plan:
- Single byte, NUM_REQ=3: req0 sends 0x55 with last=1.
  - Expect req_ready[0] in the accept cycle and tx_en=1 the next cycle with tx_data=0x55.
  - Expect active=0 one cycle after tx_busy falls; rr_ptr=1.
- Round-robin: req0, req1 and req2 all hold valid with last=1 and data 0xA0/0xA1/0xA2.
  - Expect tx_en order 0,1,2,0.
  - Expect no requester starved, and exactly one tx_en per busy period.
- Locked message: req1 sends 0x48,0x69 with last=0,1 while req0 is valid throughout.
  - Expect both req1 bytes to go out consecutively before req0 is accepted.
  - Expect grant_id=1 throughout the message.
- Lock timeout, LOCK_TIMEOUT=16: req2 sends one byte with last=0, then drops valid; req0 is valid.
  - Expect release exactly 16 cycles after entering HOLD.
  - Expect req0 to be accepted on the next IDLE cycle.
- Reset mid-byte: assert rst during WAIT_DONE.
  - Expect tx_en=0, req_ready=0, active=0 and rr_ptr=0 the following cycle.
  - Expect normal service of req1 after rst is deasserted.
- Busy guard: force tx_busy=1 while in IDLE with req0 valid.
  - Expect no req_ready and no tx_en until tx_busy=0.
